// File: rtl/liteic_slave_node_read.sv
// Read-side slave node: QoS + round-robin arbitration of master AR requests,
// single outstanding AR/R transaction forwarded to one AXI-lite slave.
module liteic_slave_node_read #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int RDATA_WIDTH = DATA_WIDTH + 2
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [NUM_MASTERS-1:0] cbar_reqst_val_i,
  output logic [NUM_MASTERS-1:0] cbar_reqst_rdy_o,
  input  logic [ADDR_WIDTH-1:0]  cbar_reqst_data_i [NUM_MASTERS],
  input  logic [3:0]             cbar_reqst_arqos_i [NUM_MASTERS],
  output logic [NUM_MASTERS-1:0] cbar_resp_val_o,
  input  logic [NUM_MASTERS-1:0] cbar_resp_rdy_i,
  output logic [RDATA_WIDTH-1:0] cbar_resp_data_o,
  output logic                   slv_ar_valid_o,
  input  logic                   slv_ar_ready_i,
  output logic [ADDR_WIDTH-1:0]  slv_ar_addr_o,
  output logic [3:0]             slv_ar_qos_o,
  input  logic                   slv_r_valid_i,
  output logic                   slv_r_ready_o,
  input  logic [DATA_WIDTH-1:0]  slv_r_data_i,
  input  logic [1:0]             slv_r_resp_i
);

  localparam int IW = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    RESP
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [IW-1:0]       r_grant;
  logic [IW-1:0]       r_rr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]          r_qos;
  logic [IW-1:0]       w_win;
  logic [IW-1:0]       w_rr_nxt;
  logic                w_any;
  logic [3:0]          w_best;

  // Scan from rr pointer; strict '>' keeps the first tied candidate.
  always_comb begin
    w_any  = 1'b0;
    w_best = 4'd0;
    w_win  = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      logic [IW:0]   w_j;
      logic [IW-1:0] w_idx;
      w_j = {1'b0, r_rr} + (IW+1)'(k);
      if (w_j >= (IW+1)'(NUM_MASTERS))
        w_j = w_j - (IW+1)'(NUM_MASTERS);
      w_idx = w_j[IW-1:0];
      if (cbar_reqst_val_i[w_idx] &&
          (!w_any || cbar_reqst_arqos_i[w_idx] > w_best)) begin
        w_any  = 1'b1;
        w_best = cbar_reqst_arqos_i[w_idx];
        w_win  = w_idx;
      end
    end
  end

  assign w_rr_nxt = (w_win == IW'(NUM_MASTERS-1)) ? '0 : w_win + 1'b1;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_rr    <= '0;
      r_addr  <= '0;
      r_qos   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_any) begin
        r_grant <= w_win;
        r_rr    <= w_rr_nxt;
        r_addr  <= cbar_reqst_data_i[w_win];
        r_qos   <= cbar_reqst_arqos_i[w_win];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_any) w_next = ADDR;
      ADDR: if (slv_ar_ready_i) w_next = RESP;
      RESP: if (slv_r_valid_i && cbar_resp_rdy_i[r_grant]) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    cbar_reqst_rdy_o = '0;
    cbar_resp_val_o  = '0;
    slv_ar_valid_o   = 1'b0;
    slv_r_ready_o    = 1'b0;
    unique case (r_state)
      IDLE: if (w_any) cbar_reqst_rdy_o[w_win] = 1'b1;
      ADDR: slv_ar_valid_o = 1'b1;
      RESP: begin
        slv_r_ready_o            = cbar_resp_rdy_i[r_grant];
        cbar_resp_val_o[r_grant] = slv_r_valid_i;
      end
      default: ;
    endcase
  end

  assign slv_ar_addr_o    = r_addr;
  assign slv_ar_qos_o     = r_qos;
  assign cbar_resp_data_o = {slv_r_data_i, slv_r_resp_i};

endmodule

// File: tb/tb_liteic_slave_node_read.sv
// Directed bench for liteic_slave_node_read: arbitration, backpressure,
// error passthrough and asynchronous reset.
module tb_liteic_slave_node_read;

  localparam int NM = 4;

  logic          clk;
  logic          rstn;
  logic [NM-1:0] req_val;
  logic [NM-1:0] req_rdy;
  logic [31:0]   req_addr [NM];
  logic [3:0]    req_qos [NM];
  logic [NM-1:0] resp_val;
  logic [NM-1:0] resp_rdy;
  logic [33:0]   resp_data;
  logic          ar_valid;
  logic          ar_ready;
  logic [31:0]   ar_addr;
  logic [3:0]    ar_qos;
  logic          r_valid;
  logic          r_ready;
  logic [31:0]   r_data;
  logic [1:0]    r_resp;

  int n_run;
  int n_fail;

  liteic_slave_node_read #(.NUM_MASTERS(NM)) dut (
    .clk_i              (clk),
    .rstn_i             (rstn),
    .cbar_reqst_val_i   (req_val),
    .cbar_reqst_rdy_o   (req_rdy),
    .cbar_reqst_data_i  (req_addr),
    .cbar_reqst_arqos_i (req_qos),
    .cbar_resp_val_o    (resp_val),
    .cbar_resp_rdy_i    (resp_rdy),
    .cbar_resp_data_o   (resp_data),
    .slv_ar_valid_o     (ar_valid),
    .slv_ar_ready_i     (ar_ready),
    .slv_ar_addr_o      (ar_addr),
    .slv_ar_qos_o       (ar_qos),
    .slv_r_valid_i      (r_valid),
    .slv_r_ready_o      (r_ready),
    .slv_r_data_i       (r_data),
    .slv_r_resp_i       (r_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int m, input logic [31:0] a,
                         input logic [3:0] q);
    req_val[m]  = 1'b1;
    req_addr[m] = a;
    req_qos[m]  = q;
  endtask

  // Starts in IDLE at negedge+1 with requests applied; ends same phase in IDLE.
  task automatic txn(input string tag, input int m, input logic [31:0] a,
                     input logic [3:0] q, input logic [31:0] rd,
                     input logic [1:0] rs, input bit keep);
    chk({tag, ".rdy"}, 64'(req_rdy), 64'(1 << m));
    @(posedge clk);
    @(negedge clk);
    if (!keep) req_val[m] = 1'b0;
    #1;
    chk({tag, ".arv"}, 64'(ar_valid), 64'd1);
    chk({tag, ".addr"}, 64'(ar_addr), 64'(a));
    chk({tag, ".qos"}, 64'(ar_qos), 64'(q));
    chk({tag, ".rdy0"}, 64'(req_rdy), 64'd0);
    ar_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ar_ready = 1'b0;
    r_valid  = 1'b1;
    r_data   = rd;
    r_resp   = rs;
    resp_rdy = '1;
    #1;
    chk({tag, ".rval"}, 64'(resp_val), 64'(1 << m));
    chk({tag, ".rdata"}, 64'(resp_data), 64'({rd, rs}));
    chk({tag, ".rrdy"}, 64'(r_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk({tag, ".idle_rval"}, 64'(resp_val), 64'd0);
    chk({tag, ".idle_rrdy"}, 64'(r_ready), 64'd0);
    r_valid = 1'b0;
    #1;
  endtask

  initial begin
    n_run    = 0;
    n_fail   = 0;
    rstn     = 1'b0;
    req_val  = '0;
    resp_rdy = '0;
    ar_ready = 1'b0;
    r_valid  = 1'b0;
    r_data   = '0;
    r_resp   = '0;
    for (int i = 0; i < NM; i++) begin
      req_addr[i] = '0;
      req_qos[i]  = '0;
    end
    #12;
    chk("rst.arv", 64'(ar_valid), 64'd0);
    chk("rst.addr", 64'(ar_addr), 64'd0);
    chk("rst.rdy", 64'(req_rdy), 64'd0);
    chk("rst.rval", 64'(resp_val), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;

    // 1: single request
    set_req(1, 32'h1000_0040, 4'd0);
    #1;
    txn("t1", 1, 32'h1000_0040, 4'd0, 32'hDEAD_BEEF, 2'b00, 1'b0);

    // 2: QoS priority, then wrap from rr=3 over {0,2}, then reset rr to 0
    set_req(0, 32'h0000_0100, 4'd1);
    set_req(2, 32'h0000_0200, 4'd7);
    set_req(3, 32'h0000_0300, 4'd3);
    #1;
    txn("t2.qos", 2, 32'h0000_0200, 4'd7, 32'h1111_2222, 2'b00, 1'b0);
    req_val = '0;
    set_req(0, 32'h0000_0A00, 4'd4);
    set_req(2, 32'h0000_0A02, 4'd4);
    #1;
    txn("t2.wrap", 0, 32'h0000_0A00, 4'd4, 32'h3333_4444, 2'b00, 1'b0);
    req_val = '0;
    set_req(3, 32'h0000_0B03, 4'd0);
    #1;
    txn("t2.m3", 3, 32'h0000_0B03, 4'd0, 32'h5555_6666, 2'b00, 1'b0);

    // 3: round-robin tie with all masters continuously valid
    for (int i = 0; i < NM; i++) set_req(i, 32'h2000_0000 + 32'(i * 4), 4'd5);
    #1;
    for (int g = 0; g < 5; g++)
      txn($sformatf("t3.g%0d", g), g % NM, 32'h2000_0000 + 32'((g % NM) * 4),
          4'd5, 32'hA000_0000 + 32'(g), 2'b00, 1'b1);
    req_val = '0;

    // 4: AR and R backpressure; master 2 waits meanwhile
    set_req(1, 32'h3000_0010, 4'd2);
    #1;
    chk("t4.rdy", 64'(req_rdy), 64'b0010);
    @(posedge clk);
    @(negedge clk);
    req_val[1] = 1'b0;
    set_req(2, 32'h3000_0020, 4'd9);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t4.arv_hold", 64'(ar_valid), 64'd1);
      chk("t4.addr_hold", 64'(ar_addr), 64'h3000_0010);
      chk("t4.rdy_hold", 64'(req_rdy), 64'd0);
      @(negedge clk);
    end
    ar_ready = 1'b1;
    @(negedge clk);
    ar_ready = 1'b0;
    r_valid  = 1'b1;
    r_data   = 32'hCAFE_F00D;
    r_resp   = 2'b00;
    resp_rdy = '0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("t4.rrdy_low", 64'(r_ready), 64'd0);
      chk("t4.rval_wait", 64'(resp_val), 64'b0010);
      chk("t4.no_grant", 64'(req_rdy), 64'd0);
      @(negedge clk);
    end
    resp_rdy[1] = 1'b1;
    #1;
    chk("t4.rrdy", 64'(r_ready), 64'd1);
    @(negedge clk);
    r_valid  = 1'b0;
    resp_rdy = '0;
    #1;

    // 5: error passthrough to master 2, others isolated
    txn("t5", 2, 32'h3000_0020, 4'd9, 32'h0BAD_0BAD, 2'b10, 1'b0);

    // 6: reset while in ADDR
    set_req(0, 32'h4000_0000, 4'd1);
    #1;
    chk("t6.rdy", 64'(req_rdy), 64'b0001);
    @(posedge clk);
    @(negedge clk);
    req_val = '0;
    #1;
    chk("t6.arv", 64'(ar_valid), 64'd1);
    rstn = 1'b0;
    #1;
    chk("t6.rst_arv", 64'(ar_valid), 64'd0);
    chk("t6.rst_addr", 64'(ar_addr), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    set_req(0, 32'h4000_0100, 4'd6);
    set_req(3, 32'h4000_0300, 4'd6);
    #1;
    txn("t6.rr0", 0, 32'h4000_0100, 4'd6, 32'h7777_8888, 2'b01, 1'b0);
    txn("t6.m3", 3, 32'h4000_0300, 4'd6, 32'h9999_AAAA, 2'b11, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
